fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_unit_branch_cond.sv | 30 +++
 rtl/fetch_pc_unit.sv | 133 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch/PC unit: branch modes, exception codes, FSM states, default vectors.
package fetch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_mode_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_IBE  = 5'd6;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} fetch_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h3000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

endpackage

// File: rtl/fetch_pc_unit_branch_cond.sv
// Combinational MIPS branch-condition resolver; rs_val compares are signed, modes 6/7 never taken.
module branch_cond
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      br_mode,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            taken
);

  logic signed [XLEN-1:0] rs_s;
  assign rs_s = $signed(rs_val);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    case (br_mode)
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLEZ: taken = (rs_s <= 0);
      BR_BGTZ: taken = (rs_s > 0);
      BR_BLTZ: taken = (rs_s < 0);
      BR_BGEZ: taken = (rs_s >= 0);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC / IR / EPC / Cause owner with ready-based fetch handshake and redirect resolution.
// Optional fetch-timeout bus error enabled by defining FETCH_TIMEOUT_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
  parameter int              TIMEOUT   = 15,
  parameter int              TO_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic            fetch_done,
  output logic [31:0]     inst_r,
  output logic [XLEN-1:0] pc,
  input  logic            br_en,
  input  logic [2:0]      br_mode,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            jump,
  input  logic            jr,
  input  logic            exc_req,
  input  logic [4:0]      exc_code,
  input  logic            eret,
  output logic [XLEN-1:0] epc,
  output logic [31:0]     cause,
  output logic            exc_taken
);

  if (XLEN < 32 || TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_param_check
    $error("fetch_pc_unit: illegal XLEN/TIMEOUT/TO_W combination");
  end

  fetch_state_e    state;
  logic            br_taken;
  logic            exc_fire;
  logic [4:0]      exc_sel;
  logic            timeout_hit;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jump_target;

  branch_cond #(.XLEN(XLEN)) u_branch_cond (
    .br_mode (br_mode),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .taken   (br_taken)
  );

  // Decoded from state so mem_req falls the instant rst clears the FSM.
  assign mem_req  = (state == WAIT);
  assign mem_addr = pc;

  assign br_target   = pc + {{(XLEN-18){inst_r[15]}}, inst_r[15:0], 2'b00};
  assign jump_target = {pc[XLEN-1:28], inst_r[25:0], 2'b00};

`ifdef FETCH_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = !mem_ready && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      to_cnt <= '0;
    else if (state == IDLE)       to_cnt <= '0;
    else if (!mem_ready)          to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Single exception-entry path; the external request outranks internally detected faults.
  always_comb begin
    exc_fire = 1'b0;
    exc_sel  = exc_code;
    if (exc_req) begin
      exc_fire = 1'b1;
    end else if (state == IDLE && !eret && jr && rs_val[1:0] != 2'b00) begin
      exc_fire = 1'b1;
      exc_sel  = EXC_ADEL;
    end else if (state == WAIT && timeout_hit) begin
      exc_fire = 1'b1;
      exc_sel  = EXC_IBE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_VEC;
      inst_r     <= '0;
      epc        <= '0;
      cause      <= '0;
      fetch_done <= 1'b0;
      exc_taken  <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      exc_taken  <= 1'b0;
      if (exc_fire) begin
        epc       <= pc;
        cause     <= {25'd0, exc_sel, 2'b00};
        pc        <= EXC_VEC;
        exc_taken <= 1'b1;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (eret)                  pc    <= epc;
            else if (jr)               pc    <= rs_val;
            else if (jump)             pc    <= jump_target;
            else if (br_en && br_taken) pc   <= br_target;
            else if (fetch_req)        state <= WAIT;
          end
          WAIT: begin
            if (mem_ready) begin
              inst_r     <= mem_rdata;
              pc         <= pc + XLEN'(4);
              fetch_done <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; expectations are hand-computed constants.
module tb_fetch_pc_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_req, mem_req, mem_ready, fetch_done;
  logic [XLEN-1:0] mem_addr, pc, rs_val, rt_val, epc;
  logic [31:0]     mem_rdata, inst_r, cause;
  logic            br_en, jump, jr, exc_req, eret, exc_taken;
  logic [2:0]      br_mode;
  logic [4:0]      exc_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .fetch_done(fetch_done), .inst_r(inst_r),
    .pc(pc), .br_en(br_en), .br_mode(br_mode), .rs_val(rs_val), .rt_val(rt_val),
    .jump(jump), .jr(jr), .exc_req(exc_req), .exc_code(exc_code), .eret(eret),
    .epc(epc), .cause(cause), .exc_taken(exc_taken)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full fetch: request, idle-wait `waits` extra WAIT cycles, then ready with `data`.
  task automatic do_fetch(input logic [31:0] data, input int waits, input logic [31:0] addr);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, addr);
    for (int i = 0; i < waits; i++) step();
    mem_ready = 1'b1;
    mem_rdata = data;
    step();
    mem_ready = 1'b0;
    check("fetch_done_pulse", fetch_done, 1);
    check("fetch_inst_r", inst_r, data);
    check("fetch_req_drop", mem_req, 0);
    step();
    check("fetch_done_clear", fetch_done, 0);
  endtask

  int              wait_cnt;
  logic [XLEN-1:0] abort_pc;

  initial begin
    rst = 1'b1; fetch_req = 0; mem_ready = 0; mem_rdata = '0;
    br_en = 0; br_mode = '0; rs_val = '0; rt_val = '0;
    jump = 0; jr = 0; exc_req = 0; exc_code = '0; eret = 0;
    #12;
    check("rst_pc", pc, 32'h3000_0000);
    check("rst_inst", inst_r, 0);
    check("rst_epc", epc, 0);
    check("rst_cause", cause, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_pulses", {fetch_done, exc_taken}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // First fetch: two extra WAIT cycles so ready lands on the third WAIT cycle.
    do_fetch(32'h2008_0005, 2, 32'h3000_0000);
    check("fetch1_pc", pc, 32'h3000_0004);
    do_fetch(32'h1422_FFFE, 0, 32'h3000_0004);
    check("fetch2_pc", pc, 32'h3000_0008);

    // Branches with imm = -2 words.
    br_en = 1; rs_val = 32'd1; rt_val = 32'd2;
    br_mode = 3'd0; step();
    check("beq_not_taken", pc, 32'h3000_0008);
    br_mode = 3'd1; step();
    check("bne_taken", pc, 32'h3000_0000);
    br_mode = 3'd3; rs_val = 32'd0; step();
    check("bgtz_zero", pc, 32'h3000_0000);
    br_mode = 3'd5; step();
    check("bgez_zero", pc, 32'h2FFF_FFF8);
    br_mode = 3'd4; rs_val = 32'h8000_0000; step();
    check("bltz_min", pc, 32'h2FFF_FFF0);
    br_mode = 3'd6; step();
    check("mode6_never", pc, 32'h2FFF_FFF0);
    br_en = 0;

    // Aligned jr, then jump using inst_r[25:0] = 0x022FFFE.
    jr = 1; rs_val = 32'h3000_0010; step(); jr = 0;
    check("jr_ok", pc, 32'h3000_0010);
    jump = 1; step(); jump = 0;
    check("jump_target", pc, 32'h308B_FFF8);

    // Misaligned jr raises address error.
    jr = 1; rs_val = 32'h0000_1002; step(); jr = 0;
    check("adel_exc_taken", exc_taken, 1);
    check("adel_cause", cause, 32'h10);
    check("adel_epc", epc, 32'h308B_FFF8);
    check("adel_pc", pc, 32'h8000_0180);
    step();
    check("adel_pulse_clear", exc_taken, 0);
    eret = 1; jump = 1; step(); eret = 0; jump = 0;
    check("eret_pc", pc, 32'h308B_FFF8);
    check("eret_cause_kept", cause, 32'h10);

    // exc_req beats jump and fetch_req in the same IDLE cycle.
    exc_req = 1; exc_code = 5'd9; jump = 1; fetch_req = 1; step();
    exc_req = 0; jump = 0; fetch_req = 0;
    check("prio_pc", pc, 32'h8000_0180);
    check("prio_cause", cause, 32'h24);
    check("prio_epc", epc, 32'h308B_FFF8);
    check("prio_no_wait", mem_req, 0);
    eret = 1; step(); eret = 0;
    check("prio_eret", pc, 32'h308B_FFF8);

    // Stalled fetch.
    fetch_req = 1; step(); fetch_req = 0;
    check("stall_mem_req", mem_req, 1);
`ifdef FETCH_TIMEOUT_EN
    wait_cnt = 1;
    while (exc_taken !== 1'b1 && wait_cnt < 40) begin
      step();
      if (exc_taken !== 1'b1) wait_cnt++;
    end
    check("to_wait_cycles", wait_cnt, 15);
    check("to_cause", cause, 32'h18);
    check("to_epc", epc, 32'h308B_FFF8);
    check("to_pc", pc, 32'h8000_0180);
    check("to_mem_req_low", mem_req, 0);
    check("to_inst_kept", inst_r, 32'h1422_FFFE);
    abort_pc = 32'h8000_0180;
    fetch_req = 1; step(); fetch_req = 0;
`else
    for (int i = 0; i < 99; i++) step();
    check("no_to_still_wait", mem_req, 1);
    abort_pc = 32'h308B_FFF8;
`endif

    // exc_req in WAIT aborts and discards a simultaneous mem_ready.
    exc_req = 1; exc_code = 5'd1; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; step();
    exc_req = 0; mem_ready = 0;
    check("abort_inst_kept", inst_r, 32'h1422_FFFE);
    check("abort_epc", epc, abort_pc);
    check("abort_pc", pc, 32'h8000_0180);
    check("abort_cause", cause, 32'h04);
    check("abort_idle", mem_req, 0);
    check("abort_no_done", fetch_done, 0);

    // pc+4 wraps to zero.
    jr = 1; rs_val = 32'hFFFF_FFFC; step(); jr = 0;
    do_fetch(32'h0000_0000, 0, 32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'h0000_0000);

    // Asynchronous reset during WAIT.
    fetch_req = 1; step(); fetch_req = 0;
    check("pre_rst_wait", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_pc", pc, 32'h3000_0000);
    check("async_rst_inst", inst_r, 0);
    #5 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
